// File: rtl/id_ex_latch_pkg.sv
// rtl/id_ex_latch_pkg.sv - shared ALU-op codes, control bit positions and width defaults for the ID/EX latch
package id_ex_latch_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        ALUOP_MTYPE   = 2'b00,
        ALUOP_ITYPE   = 2'b01,
        ALUOP_RTYPE   = 2'b10,
        ALUOP_UNKNOWN = 2'b11
    } aluop_e;

    // wb field {regwrite, memtoreg}
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    // m field {branch, memread, memwrite}
    localparam int M_BRANCH    = 2;
    localparam int M_MEMREAD   = 1;
    localparam int M_MEMWRITE  = 0;
    // ex field {regdst, aluop[1:0], alusrc}
    localparam int EX_REGDST   = 3;
    localparam int EX_ALUOP_HI = 2;
    localparam int EX_ALUOP_LO = 1;
    localparam int EX_ALUSRC   = 0;

    // wb + m + ex + valid
    localparam int CTRL_W = 2 + 3 + 4 + 1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/id_ex_latch_if.sv
// rtl/id_ex_latch_if.sv - decode-side inputs and execute-side outputs of the ID/EX latch (rs fields under ID_EX_FORWARDING_EN)
interface id_ex_latch_if
    import id_ex_latch_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
);
    logic              stall;
    logic              flush;
    logic [1:0]        wb_in;
    logic [2:0]        m_in;
    logic [3:0]        ex_in;
    logic [DATA_W-1:0] npc_in;
    logic [DATA_W-1:0] rd1_in;
    logic [DATA_W-1:0] rd2_in;
    logic [DATA_W-1:0] imm_in;
    logic [REG_AW-1:0] rt_in;
    logic [REG_AW-1:0] rd_in;

    logic [1:0]        wb_out;
    logic [2:0]        m_out;
    logic              regdst;
    logic [1:0]        aluop;
    logic              alusrc;
    logic [5:0]        funct;
    logic [DATA_W-1:0] npc_out;
    logic [DATA_W-1:0] rd1_out;
    logic [DATA_W-1:0] rd2_out;
    logic [DATA_W-1:0] imm_out;
    logic [REG_AW-1:0] rt_out;
    logic [REG_AW-1:0] rd_out;
    logic              valid;
    logic [15:0]       bubble_cnt;
`ifdef ID_EX_FORWARDING_EN
    logic [REG_AW-1:0] rs_in;
    logic [REG_AW-1:0] rs_out;
`endif

    modport master (
        output stall, flush, wb_in, m_in, ex_in, npc_in, rd1_in, rd2_in, imm_in, rt_in, rd_in,
`ifdef ID_EX_FORWARDING_EN
        output rs_in,
        input  rs_out,
`endif
        input  wb_out, m_out, regdst, aluop, alusrc, funct, npc_out, rd1_out, rd2_out,
        input  imm_out, rt_out, rd_out, valid, bubble_cnt
    );

    modport slave (
        input  stall, flush, wb_in, m_in, ex_in, npc_in, rd1_in, rd2_in, imm_in, rt_in, rd_in,
`ifdef ID_EX_FORWARDING_EN
        input  rs_in,
        output rs_out,
`endif
        output wb_out, m_out, regdst, aluop, alusrc, funct, npc_out, rd1_out, rd2_out,
        output imm_out, rt_out, rd_out, valid, bubble_cnt
    );

endinterface

// File: rtl/id_ex_latch_pipe_reg.sv
// rtl/id_ex_latch_pipe_reg.sv - generic pipeline register with reset, clear and stall, in that priority
module pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // next value: clear beats stall, stall holds, otherwise load
    always_comb begin
        q_d = q_q;
        if (clear) begin
            q_d = '0;
        end else if (!stall) begin
            q_d = d;
        end
    end

    // state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/id_ex_latch.sv
// rtl/id_ex_latch.sv - ID/EX pipeline latch with flush bubbles and bubble counter; ID_EX_FORWARDING_EN adds rs field
module id_ex_latch
    import id_ex_latch_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input logic         clk,
    input logic         rst,
    id_ex_latch_if.slave bus
);
`ifdef ID_EX_FORWARDING_EN
    localparam int DATA_GW = 4 * DATA_W + 3 * REG_AW;
`else
    localparam int DATA_GW = 4 * DATA_W + 2 * REG_AW;
`endif

    logic [CTRL_W-1:0]  ctrl_d;
    logic [CTRL_W-1:0]  ctrl_q;
    logic [DATA_GW-1:0] data_d;
    logic [DATA_GW-1:0] data_q;
    logic               data_stall;
    logic [15:0]        bubble_cnt_d;
    logic [15:0]        bubble_cnt_q;

    // control group: a flush zeroes it (including valid), a stall holds it
    assign ctrl_d = {bus.wb_in, bus.m_in, bus.ex_in, 1'b1};

    pipe_reg #(.W(CTRL_W)) u_ctrl (
        .clk   (clk),
        .rst   (rst),
        .stall (bus.stall),
        .clear (bus.flush),
        .d     (ctrl_d),
        .q     (ctrl_q)
    );

    // data group is never cleared; on a flush it still captures so flush beats stall
    assign data_stall = bus.stall & ~bus.flush;
`ifdef ID_EX_FORWARDING_EN
    assign data_d = {bus.npc_in, bus.rd1_in, bus.rd2_in, bus.imm_in, bus.rt_in, bus.rd_in, bus.rs_in};
`else
    assign data_d = {bus.npc_in, bus.rd1_in, bus.rd2_in, bus.imm_in, bus.rt_in, bus.rd_in};
`endif

    pipe_reg #(.W(DATA_GW)) u_data (
        .clk   (clk),
        .rst   (rst),
        .stall (data_stall),
        .clear (1'b0),
        .d     (data_d),
        .q     (data_q)
    );

    // bubble counter: one per flush edge, saturating
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (bus.flush) begin
            bubble_cnt_d = sat_inc16(bubble_cnt_q);
        end
    end

    // bubble counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= 16'd0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.wb_out     = ctrl_q[9:8];
    assign bus.m_out      = ctrl_q[7:5];
    assign bus.regdst     = ctrl_q[1 + EX_REGDST];
    assign bus.aluop      = ctrl_q[1 + EX_ALUOP_HI -: 2];
    assign bus.alusrc     = ctrl_q[1 + EX_ALUSRC];
    assign bus.valid      = ctrl_q[0];
    assign bus.bubble_cnt = bubble_cnt_q;

`ifdef ID_EX_FORWARDING_EN
    assign {bus.npc_out, bus.rd1_out, bus.rd2_out, bus.imm_out, bus.rt_out, bus.rd_out, bus.rs_out} = data_q;
`else
    assign {bus.npc_out, bus.rd1_out, bus.rd2_out, bus.imm_out, bus.rt_out, bus.rd_out} = data_q;
`endif
    assign bus.funct = bus.imm_out[5:0];

endmodule

// File: tb/tb_id_ex_latch.sv
// tb/tb_id_ex_latch.sv - randomized and directed bench for id_ex_latch against a behavioural model
module tb_id_ex_latch;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    id_ex_latch_if #(.DATA_W(32), .REG_AW(5)) bus ();

    id_ex_latch #(.DATA_W(32), .REG_AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // behavioural model of what the stage must hold
    logic [1:0]  e_wb;
    logic [2:0]  e_m;
    logic [3:0]  e_ex;
    logic        e_valid;
    logic [31:0] e_npc, e_rd1, e_rd2, e_imm;
    logic [4:0]  e_rt, e_rd, e_rs;
    int          e_cnt;

    always @(posedge clk) begin
        if (rst) begin
            e_wb = 0; e_m = 0; e_ex = 0; e_valid = 0;
            e_npc = 0; e_rd1 = 0; e_rd2 = 0; e_imm = 0; e_rt = 0; e_rd = 0; e_rs = 0;
            e_cnt = 0;
        end else if (bus.flush || !bus.stall) begin
            e_npc = bus.npc_in; e_rd1 = bus.rd1_in; e_rd2 = bus.rd2_in; e_imm = bus.imm_in;
            e_rt = bus.rt_in; e_rd = bus.rd_in;
`ifdef ID_EX_FORWARDING_EN
            e_rs = bus.rs_in;
`endif
            if (bus.flush) begin
                e_wb = 0; e_m = 0; e_ex = 0; e_valid = 0;
                if (e_cnt < 65535) e_cnt = e_cnt + 1;
            end else begin
                e_wb = bus.wb_in; e_m = bus.m_in; e_ex = bus.ex_in; e_valid = 1;
            end
        end
    end

    // compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        logic [255:0] act, exp;
        if (chk_en) begin
            act = {bus.wb_out, bus.m_out, bus.regdst, bus.aluop, bus.alusrc, bus.funct, bus.valid,
                   bus.npc_out, bus.rd1_out, bus.rd2_out, bus.imm_out, bus.rt_out, bus.rd_out};
            exp = {e_wb, e_m, e_ex, e_imm[5:0], e_valid, e_npc, e_rd1, e_rd2, e_imm, e_rt, e_rd};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t actual=%h expected=%h", $time, act, exp);
            end
            checks++;
            if (bus.bubble_cnt !== e_cnt[15:0]) begin
                errors++;
                $display("FAIL cycle_bubble_cnt t=%0t actual=%h expected=%h", $time, bus.bubble_cnt, e_cnt[15:0]);
            end
`ifdef ID_EX_FORWARDING_EN
            checks++;
            if (bus.rs_out !== e_rs) begin
                errors++;
                $display("FAIL cycle_rs_out t=%0t actual=%h expected=%h", $time, bus.rs_out, e_rs);
            end
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic rand_data();
        bus.npc_in = $urandom; bus.rd1_in = $urandom; bus.rd2_in = $urandom; bus.imm_in = $urandom;
        bus.rt_in = 5'($urandom); bus.rd_in = 5'($urandom);
`ifdef ID_EX_FORWARDING_EN
        bus.rs_in = 5'($urandom);
`endif
    endtask

    task automatic set_ctrl(input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex);
        bus.wb_in = wb; bus.m_in = m; bus.ex_in = ex;
    endtask

    initial begin
        rst = 1'b1; bus.stall = 1'b1; bus.flush = 1'b1;
        set_ctrl(2'b11, 3'b111, 4'b1111);
        rand_data();
        tick();
        chk_en = 1'b1;
        // reset beats flush and stall for two cycles
        for (int i = 0; i < 2; i++) begin
            check("reset_valid", 32'(bus.valid), 32'd0);
            check("reset_cnt", 32'(bus.bubble_cnt), 32'd0);
            check("reset_aluop", 32'(bus.aluop), 32'd0);
            check("reset_imm", bus.imm_out, 32'd0);
            if (i == 0) tick();
        end
        rst = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;

        // R-type add
        set_ctrl(2'b10, 3'b000, 4'b1100);
        bus.imm_in = 32'h00000020;
        tick();
        check("rtype_aluop", 32'(bus.aluop), 32'd2);
        check("rtype_regdst", 32'(bus.regdst), 32'd1);
        check("rtype_funct", 32'(bus.funct), 32'h20);
        check("rtype_regwrite", 32'(bus.wb_out[1]), 32'd1);
        check("rtype_valid", 32'(bus.valid), 32'd1);

        // aluop 11 passes through untouched
        set_ctrl(2'b00, 3'b000, 4'b0110);
        tick();
        check("aluop_11", 32'(bus.aluop), 32'd3);

        // lw then 3 stalled cycles with sw on the inputs
        set_ctrl(2'b11, 3'b010, 4'b0001);
        rand_data();
        tick();
        check("lw_m", 32'(bus.m_out), 32'b010);
        bus.stall = 1'b1;
        set_ctrl(2'b00, 3'b001, 4'b0001);
        rand_data();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_memread", 32'(bus.m_out), 32'b010);
            check("stall_aluop", 32'(bus.aluop), 32'd0);
            check("stall_valid", 32'(bus.valid), 32'd1);
            check("stall_wb", 32'(bus.wb_out), 32'b11);
        end

        // flush with stall: bubble wins
        bus.flush = 1'b1;
        set_ctrl(2'b10, 3'b010, 4'b1100);
        tick();
        check("flush_wb", 32'(bus.wb_out), 32'd0);
        check("flush_m", 32'(bus.m_out), 32'd0);
        check("flush_valid", 32'(bus.valid), 32'd0);
        check("flush_cnt", 32'(bus.bubble_cnt), 32'd1);
        bus.flush = 1'b0; bus.stall = 1'b0;

        // counter saturation
        rst = 1'b1;
        tick();
        rst = 1'b0; bus.flush = 1'b1;
        for (int i = 0; i < 65534; i++) tick();
        check("sat_preload", 32'(bus.bubble_cnt), 32'hFFFE);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sat_hold", 32'(bus.bubble_cnt), 32'hFFFF);
        end
        bus.flush = 1'b0;
        tick();
        check("sat_after", 32'(bus.bubble_cnt), 32'hFFFF);

        // reset during a stall drops the held instruction
        bus.stall = 1'b1; rst = 1'b1;
        tick();
        check("rst_stall_valid", 32'(bus.valid), 32'd0);
        check("rst_stall_wb", 32'(bus.wb_out), 32'd0);
        check("rst_stall_cnt", 32'(bus.bubble_cnt), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_stall_valid", 32'(bus.valid), 32'd0);

`ifdef ID_EX_FORWARDING_EN
        bus.stall = 1'b0; bus.flush = 1'b0;
        bus.rs_in = 5'd9;
        tick();
        check("rs_load", 32'(bus.rs_out), 32'd9);
        rst = 1'b1;
        tick();
        check("rs_reset", 32'(bus.rs_out), 32'd0);
        rst = 1'b0;
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            bus.flush = ($urandom_range(0, 5) == 0);
            bus.stall = ($urandom_range(0, 3) == 0);
            set_ctrl(2'($urandom), 3'($urandom), 4'($urandom));
            rand_data();
            tick();
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
